mtm_alu_deserializer: RTL and testbench
=======================================

# mtm_alu_deserializer

Serial input stage of the mtm_Alu. It samples the one-bit `sin` line, reassembles 11-bit frames into eight DATA bytes and one CTL byte, checks packet structure and CRC4, and presents operands B, A and the opcode to the ALU core through a valid/ready handshake. Malformed packets produce an error-flag word in place of operands, which the serializer downstream reports as an error frame.

## Interface
- `CRC_INIT`, 4'h0: CRC4 seed value.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `sin`  in  1  serial data, synchronous to `clk`, idle high, one bit per cycle.
- `a_o`  out  32  operand A.
- `b_o`  out  32  operand B.
- `op_o`  out  3  opcode.
- `err_o`  out  3  error flags {ERR_DATA, ERR_CRC, ERR_OP}; all zero for a good packet.
- `valid_o`  out  1  result (operands or error) pending.
- `ready_i`  in  1  consumer accepts the pending result.
- `overrun_o`  out  1  one-cycle pulse: a completed packet was dropped.

## Operation
- Frame, 11 bits in order: start `0`; type bit (`0` = DATA, `1` = CTL); 8 payload bits, MSB first; stop `1`.
- Packet: 8 DATA frames, then 1 CTL frame.
  - DATA frames carry B[31:24], B[23:16], B[15:8], B[7:0], then A[31:24] through A[7:0].
  - CTL = {1'b0, OP[2:0], CRC[3:0]}.
- Frame FSM states:
  - IDLE: wait for `sin`=0.
  - TYPE: sample the type bit.
  - DATA: 8 bit counter.
  - STOP: check the stop bit.
  - Return to IDLE after STOP. Back-to-back frames are allowed: a start bit may arrive in the cycle after the stop bit.
- Stop bit sampled 0 (framing error):
  - Discard the frame and abort the packet: clear the data count and CRC.
  - Return to IDLE. No result is produced.
- DATA frame handling:
  - Shift the byte into a 64-bit {B,A} register.
  - Increment the data count, saturating at 9. Bytes beyond the 8th are not stored.
- CTL frame resolves the packet:
  - Data count ≠ 8: ERR_DATA.
  - Otherwise, computed CRC ≠ CTL[3:0]: ERR_CRC. The CRC covers the 68 bits {B, A, 1'b1, OP}, MSB first, polynomial x^4+x+1, seeded with `CRC_INIT`.
  - Otherwise, OP not in {000 AND, 001 OR, 100 ADD, 101 SUB}: ERR_OP.
  - Exactly one flag is set; priority is DATA > CRC > OP.
  - The data count and CRC are cleared after every CTL frame.
- Output register:
  - Load `a_o`, `b_o`, `op_o` and `err_o`, and set `valid_o`.
  - On an error, `a_o`, `b_o` and `op_o` are loaded with 0.
- Handshake:
  - A transfer occurs on a cycle with `valid_o`=1 and `ready_i`=1.
  - Outputs are stable while `valid_o`=1 and `ready_i`=0.
- Packet resolves while a result is pending and not transferred in that cycle: drop the new result and pulse `overrun_o`.
- Packet resolves in the same cycle as a transfer: load the new result and keep `valid_o`=1.
- Reception never stalls under backpressure.

## Timing
- Reset values: `a_o`=0, `b_o`=0, `op_o`=0, `err_o`=0, `valid_o`=0, `overrun_o`=0. The FSM is in IDLE with the data count and CRC cleared.
- Reset asserted mid-frame or mid-packet discards all partial state. After release, the first `sin`=0 is treated as a start bit.
- The stop bit of a frame is sampled on clock edge N. The frame's effect is registered on edge N, so it is visible after edge N.
- For the CTL frame, `valid_o` rises after edge N: one clock of latency from stop-bit sampling.
- A full packet takes 99 cycles minimum.
- `valid_o` falls on the edge that completes the transfer, unless a new result loads on that same edge.
- `overrun_o` is high for exactly one cycle per dropped packet.

## Test plan
- Good ADD: B=3, A=4, OP=100, correct CRC. Expect `valid_o`; `a_o`=4, `b_o`=3, `op_o`=100, `err_o`=000.
- CRC error: same operands, CTL CRC field = correct CRC XOR 4'hF. Expect `err_o`=010 and `a_o`/`b_o`=0.
- Short packet: DATA 0x55, DATA 0x0F, then CTL 0x50. Expect `err_o`=100. Then send a 10-DATA-frame packet followed by CTL. Expect `err_o`=100 again.
- Bad opcode: OP=010 with correct CRC. Expect `err_o`=001. Max operands (A=B=0xFFFFFFFF) with each of the four valid ops: all return `err_o`=000 with operands intact.
- Backpressure: hold `ready_i`=0 and send two good packets. Expect the first result held stable and one `overrun_o` pulse. Then raise `ready_i` and expect a single transfer.
- Robustness:
  - Stop bit forced to 0 in frame 3: no result. The next good packet is decoded correctly.
  - `rst` pulsed during frame 5: no result. The next packet is decoded correctly.

Source files
------------

// File: rtl/mtm_alu_deserializer_if.sv
// Result bus from the mtm_Alu serial input stage to the ALU core:
// operands/opcode/error flags with a valid/ready handshake plus an overrun pulse.
`timescale 1ns/1ps
interface mtm_alu_deserializer_if;
  logic [31:0] a_o;
  logic [31:0] b_o;
  logic [2:0]  op_o;
  logic [2:0]  err_o;
  logic        valid_o;
  logic        ready_i;
  logic        overrun_o;

  modport master (
    output a_o, b_o, op_o, err_o, valid_o, overrun_o,
    input  ready_i
  );

  modport slave (
    input  a_o, b_o, op_o, err_o, valid_o, overrun_o,
    output ready_i
  );
endinterface

// File: rtl/mtm_alu_deserializer.sv
// mtm_Alu serial input stage: reassembles 11-bit frames into {B,A,OP},
// checks packet length, CRC4 and opcode, and presents a result via valid/ready.
`timescale 1ns/1ps
module mtm_alu_deserializer #(
  parameter logic [3:0] CRC_INIT = 4'h0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sin,
  mtm_alu_deserializer_if.master        bus
);

  typedef enum logic [1:0] {S_IDLE, S_TYPE, S_DATA, S_STOP} state_t;

  localparam logic [2:0] ERR_DATA = 3'b100;
  localparam logic [2:0] ERR_CRC  = 3'b010;
  localparam logic [2:0] ERR_OP   = 3'b001;

  // Serial CRC4, x^4+x+1, consuming the top n bits of 'bits' MSB first.
  function automatic logic [3:0] crc4_shift(input logic [3:0] crc, input logic [7:0] bits,
                                            input int unsigned n);
    logic [3:0] c;
    logic [7:0] d;
    logic       fb;
    c = crc;
    d = bits;
    for (int unsigned i = 0; i < n; i++) begin
      fb = c[3] ^ d[7];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
      d  = {d[6:0], 1'b0};
    end
    return c;
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  byte_q, byte_d;
  logic        type_q, type_d;
  logic [63:0] ba_q, ba_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  crc_q, crc_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic [2:0]  err_q, err_d;
  logic        valid_q, valid_d;
  logic        overrun_q, overrun_d;

  logic [2:0]  ctl_op;
  logic [3:0]  ctl_crc;
  logic [2:0]  ctl_err;
  logic        xfer;

  // Packet verdict from the CTL byte; only consumed when a CTL stop bit is good.
  always_comb begin
    ctl_op  = byte_q[6:4];
    ctl_crc = crc4_shift(crc_q, {1'b1, ctl_op, 4'b0000}, 4);
    ctl_err = '0;
    if (cnt_q != 4'd8) begin
      ctl_err = ERR_DATA;
    end else if (ctl_crc != byte_q[3:0]) begin
      ctl_err = ERR_CRC;
    end else begin
      case (ctl_op)
        3'b000, 3'b001, 3'b100, 3'b101: ctl_err = '0;
        default:                        ctl_err = ERR_OP;
      endcase
    end
  end

  assign xfer = valid_q & bus.ready_i;

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    byte_d    = byte_q;
    type_d    = type_q;
    ba_d      = ba_q;
    cnt_d     = cnt_q;
    crc_d     = crc_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    err_d     = err_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;

    if (xfer) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (!sin) begin
          state_d = S_TYPE;
        end
      end
      S_TYPE: begin
        type_d   = sin;
        bitcnt_d = '0;
        state_d  = S_DATA;
      end
      S_DATA: begin
        byte_d   = {byte_q[6:0], sin};
        bitcnt_d = bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        state_d = S_IDLE;
        if (!sin) begin
          cnt_d = '0;
          crc_d = CRC_INIT;
        end else if (!type_q) begin
          if (cnt_q < 4'd8) begin
            ba_d  = {ba_q[55:0], byte_q};
            crc_d = crc4_shift(crc_q, byte_q, 8);
          end
          if (cnt_q != 4'd9) begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          cnt_d = '0;
          crc_d = CRC_INIT;
          // A pending result that is not leaving this cycle wins; the new one is dropped.
          if (valid_q && !bus.ready_i) begin
            overrun_d = 1'b1;
          end else begin
            valid_d = 1'b1;
            err_d   = ctl_err;
            if (ctl_err == 3'b000) begin
              b_d  = ba_q[63:32];
              a_d  = ba_q[31:0];
              op_d = ctl_op;
            end else begin
              b_d  = '0;
              a_d  = '0;
              op_d = '0;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bitcnt_q  <= '0;
      byte_q    <= '0;
      type_q    <= 1'b0;
      ba_q      <= '0;
      cnt_q     <= '0;
      crc_q     <= CRC_INIT;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      err_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      byte_q    <= byte_d;
      type_q    <= type_d;
      ba_q      <= ba_d;
      cnt_q     <= cnt_d;
      crc_q     <= crc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.a_o       = a_q;
  assign bus.b_o       = b_q;
  assign bus.op_o      = op_q;
  assign bus.err_o     = err_q;
  assign bus.valid_o   = valid_q;
  assign bus.overrun_o = overrun_q;

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Bench for mtm_alu_deserializer: directed and random packets checked against a
// packet-level reference model (CRC by polynomial long division).
`timescale 1ns/1ps
module tb_mtm_alu_deserializer;

  localparam logic [3:0] SEED = 4'h0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [2:0]  err;
  } res_t;

  typedef logic [7:0] bytes_t[$];

  logic clk = 1'b0;
  logic rst;
  logic sin;

  mtm_alu_deserializer_if dut_if();

  mtm_alu_deserializer #(.CRC_INIT(SEED)) dut (
    .clk (clk),
    .rst (rst),
    .sin (sin),
    .bus (dut_if)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned ovr_cnt = 0;
  res_t        exp_q[$];
  res_t        got_q[$];

  task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Remainder of (msg * x^4) mod x^4+x+1; a nonzero seed folds into the first four message bits.
  function automatic logic [3:0] crc_ref(input logic [67:0] msg);
    logic [71:0] r;
    r = {msg ^ {SEED, 64'h0}, 4'h0};
    for (int i = 0; i < 68; i++) begin
      if (r[71]) r = r ^ {5'b10011, 67'h0};
      r = r << 1;
    end
    return r[71:68];
  endfunction

  function automatic logic [7:0] make_ctl(input logic [31:0] b, input logic [31:0] a,
                                          input logic [2:0] op);
    return {1'b0, op, crc_ref({b, a, 1'b1, op})};
  endfunction

  function automatic bytes_t to_bytes(input logic [31:0] b, input logic [31:0] a);
    bytes_t q;
    q = {b[31:24], b[23:16], b[15:8], b[7:0], a[31:24], a[23:16], a[15:8], a[7:0]};
    return q;
  endfunction

  function automatic res_t model(input bytes_t d, input logic [7:0] ctl);
    res_t        r;
    logic [31:0] b;
    logic [31:0] a;
    logic [2:0]  op;
    r = '0;
    if (d.size() != 8) begin
      r.err = 3'b100;
    end else begin
      b  = {d[0], d[1], d[2], d[3]};
      a  = {d[4], d[5], d[6], d[7]};
      op = ctl[6:4];
      if (crc_ref({b, a, 1'b1, op}) != ctl[3:0]) r.err = 3'b010;
      else if (!(op inside {3'b000, 3'b001, 3'b100, 3'b101})) r.err = 3'b001;
      else begin
        r.a  = a;
        r.b  = b;
        r.op = op;
      end
    end
    return r;
  endfunction

  task automatic send_bit(input logic v);
    @(negedge clk);
    sin = v;
  endtask

  task automatic send_frame(input logic typ, input logic [7:0] byt, input logic stop,
                            input logic rdy_on_stop);
    logic [7:0] s;
    s = byt;
    send_bit(1'b0);
    send_bit(typ);
    for (int i = 0; i < 8; i++) begin
      send_bit(s[7]);
      s = s << 1;
    end
    @(negedge clk);
    sin = stop;
    if (rdy_on_stop) dut_if.ready_i = 1'b1;
  endtask

  task automatic send_packet(input bytes_t d, input logic [7:0] ctl, input logic rdy_on_stop);
    foreach (d[i]) send_frame(1'b0, d[i], 1'b1, 1'b0);
    send_frame(1'b1, ctl, 1'b1, rdy_on_stop);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sin = 1'b1;
    end
  endtask

  task automatic expect_results(input string tag);
    idle(6);
    check({tag, ".count"}, 70'(got_q.size()), 70'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) check(tag, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  // Inputs change on negedge; by negedge+1 they hold the values seen at the next posedge.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (dut_if.valid_o && dut_if.ready_i)
        got_q.push_back({dut_if.a_o, dut_if.b_o, dut_if.op_o, dut_if.err_o});
      if (dut_if.overrun_o) ovr_cnt++;
    end
  end

  initial begin
    bytes_t      d;
    logic [7:0]  ctl;
    logic [31:0] rb;
    logic [31:0] ra;
    logic [2:0]  rop;
    logic [2:0]  ops[4];
    res_t        e1;
    int unsigned kind;

    ops = '{3'b000, 3'b001, 3'b100, 3'b101};
    rst = 1'b1;
    sin = 1'b1;
    dut_if.ready_i = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.result", 70'({dut_if.a_o, dut_if.b_o, dut_if.op_o, dut_if.err_o}), 70'(0));
    check("rst.valid", 70'(dut_if.valid_o), 70'(0));
    check("rst.overrun", 70'(dut_if.overrun_o), 70'(0));
    rst = 1'b0;
    idle(3);

    // Good ADD with exact one-clock latency after the CTL stop bit
    send_packet(to_bytes(32'd3, 32'd4), make_ctl(32'd3, 32'd4, 3'b100), 1'b0);
    check("add.prevalid", 70'(dut_if.valid_o), 70'(0));
    idle(1);
    check("add.latency", 70'(dut_if.valid_o), 70'(1));
    exp_q.push_back(res_t'{a: 32'd4, b: 32'd3, op: 3'b100, err: 3'b000});
    expect_results("add");
    check("add.valid_fall", 70'(dut_if.valid_o), 70'(0));

    send_packet(to_bytes(32'd3, 32'd4), make_ctl(32'd3, 32'd4, 3'b100) ^ 8'h0F, 1'b0);
    exp_q.push_back(res_t'{a: 32'd0, b: 32'd0, op: 3'b000, err: 3'b010});
    expect_results("crc_err");

    d = {8'h55, 8'h0F};
    send_packet(d, 8'h50, 1'b0);
    exp_q.push_back(res_t'{a: 32'd0, b: 32'd0, op: 3'b000, err: 3'b100});
    expect_results("short");

    d = to_bytes(32'h01234567, 32'h89ABCDEF);
    d.push_back(8'hA5);
    d.push_back(8'h3C);
    send_packet(d, make_ctl(32'h01234567, 32'h89ABCDEF, 3'b100), 1'b0);
    exp_q.push_back(res_t'{a: 32'd0, b: 32'd0, op: 3'b000, err: 3'b100});
    expect_results("long");

    send_packet(to_bytes(32'd3, 32'd4), make_ctl(32'd3, 32'd4, 3'b010), 1'b0);
    exp_q.push_back(res_t'{a: 32'd0, b: 32'd0, op: 3'b000, err: 3'b001});
    expect_results("bad_op");

    for (int i = 0; i < 4; i++) begin
      send_packet(to_bytes('1, '1), make_ctl('1, '1, ops[i]), 1'b0);
      exp_q.push_back(res_t'{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, op: ops[i], err: 3'b000});
      idle($urandom_range(0, 2));
    end
    expect_results("max_ops");

    // Backpressure: second packet dropped with one overrun pulse, first held
    ovr_cnt = 0;
    dut_if.ready_i = 1'b0;
    rb = $urandom();
    ra = $urandom();
    e1 = res_t'{a: ra, b: rb, op: 3'b101, err: 3'b000};
    send_packet(to_bytes(rb, ra), make_ctl(rb, ra, 3'b101), 1'b0);
    idle(2);
    check("bp.first", 70'({dut_if.a_o, dut_if.b_o, dut_if.op_o, dut_if.err_o}), 70'(e1));
    send_packet(to_bytes(~rb, ~ra), make_ctl(~rb, ~ra, 3'b001), 1'b0);
    idle(4);
    check("bp.hold", 70'({dut_if.a_o, dut_if.b_o, dut_if.op_o, dut_if.err_o}), 70'(e1));
    check("bp.valid", 70'(dut_if.valid_o), 70'(1));
    check("bp.overrun", 70'(ovr_cnt), 70'(1));
    dut_if.ready_i = 1'b1;
    exp_q.push_back(e1);
    expect_results("bp");

    // Packet resolves on the same edge as the pending transfer
    ovr_cnt = 0;
    dut_if.ready_i = 1'b0;
    send_packet(to_bytes(32'd10, 32'd20), make_ctl(32'd10, 32'd20, 3'b000), 1'b0);
    exp_q.push_back(res_t'{a: 32'd20, b: 32'd10, op: 3'b000, err: 3'b000});
    idle(3);
    send_packet(to_bytes(32'd30, 32'd40), make_ctl(32'd30, 32'd40, 3'b001), 1'b1);
    exp_q.push_back(res_t'{a: 32'd40, b: 32'd30, op: 3'b001, err: 3'b000});
    expect_results("same_edge");
    check("same_edge.overrun", 70'(ovr_cnt), 70'(0));

    // Framing error in the third frame aborts the packet
    d = to_bytes(32'hDEADBEEF, 32'h0BADF00D);
    send_frame(1'b0, d[0], 1'b1, 1'b0);
    send_frame(1'b0, d[1], 1'b1, 1'b0);
    send_frame(1'b0, d[2], 1'b0, 1'b0);
    idle(12);
    check("frm.valid", 70'(dut_if.valid_o), 70'(0));
    expect_results("frm.none");
    send_packet(to_bytes(32'd7, 32'd9), make_ctl(32'd7, 32'd9, 3'b101), 1'b0);
    exp_q.push_back(res_t'{a: 32'd9, b: 32'd7, op: 3'b101, err: 3'b000});
    expect_results("frm.next");

    // Reset pulse in the middle of the fifth frame
    for (int i = 0; i < 4; i++) send_frame(1'b0, d[i], 1'b1, 1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    #2 rst = 1'b1;
    @(negedge clk);
    sin = 1'b1;
    rst = 1'b0;
    idle(12);
    check("rst_mid.valid", 70'(dut_if.valid_o), 70'(0));
    expect_results("rst_mid.none");
    send_packet(to_bytes(32'h80000000, 32'h7FFFFFFF), make_ctl(32'h80000000, 32'h7FFFFFFF, 3'b100), 1'b0);
    exp_q.push_back(res_t'{a: 32'h7FFFFFFF, b: 32'h80000000, op: 3'b100, err: 3'b000});
    expect_results("rst_mid.next");

    // Random packets with occasional corruption and brief backpressure
    ovr_cnt = 0;
    for (int n = 0; n < 30; n++) begin
      rb   = $urandom();
      ra   = $urandom();
      rop  = 3'($urandom_range(0, 7));
      kind = $urandom_range(0, 9);
      d    = to_bytes(rb, ra);
      ctl  = make_ctl(rb, ra, rop);
      if (kind == 0) begin
        ctl = ctl ^ {4'h0, 4'($urandom_range(1, 15))};
      end else if (kind == 1) begin
        d.delete();
        for (int k = $urandom_range(0, 12); k > 0; k--) d.push_back(8'($urandom()));
        ctl = 8'($urandom());
      end
      dut_if.ready_i = 1'($urandom_range(0, 1));
      send_packet(d, ctl, 1'b0);
      exp_q.push_back(model(d, ctl));
      idle($urandom_range(0, 5));
      dut_if.ready_i = 1'b1;
      idle($urandom_range(1, 3));
    end
    expect_results("rand");
    check("rand.overrun", 70'(ovr_cnt), 70'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
